// File: rtl/sensors_acquire.sv
`default_nettype none
// ============================================================================
// Module   : sensors_acquire
// Purpose  : Polls four distance sensors over a shared req/ack byte bus and
//            publishes all readings as one coherent frame (0 = timed out).
// Revision : 1.0 - initial release
// ============================================================================
module sensors_acquire #(
  parameter int TIMEOUT = 15,
  parameter int TW      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic [1:0] sns_sel,
  output logic       sns_req,
  input  logic       sns_ack,
  input  logic [7:0] sns_data,
  output logic [7:0] sensor1,
  output logic [7:0] sensor2,
  output logic [7:0] sensor3,
  output logic [7:0] sensor4,
  output logic [3:0] timeout_mask,
  output logic       frame_valid
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [2:0][7:0]    shadow_q, shadow_d;
  logic [2:0]         shmask_q, shmask_d;
  logic [3:0][7:0]    sensor_q, sensor_d;
  logic [3:0]         tmask_q, tmask_d;
  logic               fvalid_q, fvalid_d;

  logic               resolved;
  logic               timed_out;
  logic [7:0]         reading;

  // A response or an expired timer both close the current WAIT; ack has priority.
  assign resolved  = sns_ack || (timer_q == TIMER_LAST);
  assign timed_out = !sns_ack;
  assign reading   = sns_ack ? sns_data : 8'd0;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    timer_d  = timer_q;
    shadow_d = shadow_q;
    shmask_d = shmask_q;
    sensor_d = sensor_q;
    tmask_d  = tmask_q;
    fvalid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_REQ;
          sel_d    = 2'd0;
          shadow_d = '0;
          shmask_d = '0;
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
        timer_d = '0;
      end
      ST_WAIT: begin
        if (resolved) begin
          if (sel_q == 2'd3) begin
            // Last sensor bypasses the shadow so the frame lands in one edge.
            sensor_d = {reading, shadow_q[2], shadow_q[1], shadow_q[0]};
            tmask_d  = {timed_out, shmask_q};
            fvalid_d = 1'b1;
            sel_d    = 2'd0;
            state_d  = ST_IDLE;
          end else begin
            shadow_d[sel_q] = reading;
            shmask_d[sel_q] = timed_out;
            sel_d           = sel_q + 2'd1;
            state_d         = ST_REQ;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= 2'd0;
      timer_q  <= '0;
      shadow_q <= '0;
      shmask_q <= '0;
      sensor_q <= '0;
      tmask_q  <= '0;
      fvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      timer_q  <= timer_d;
      shadow_q <= shadow_d;
      shmask_q <= shmask_d;
      sensor_q <= sensor_d;
      tmask_q  <= tmask_d;
      fvalid_q <= fvalid_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign sns_req      = (state_q == ST_REQ);
  assign sns_sel      = sel_q;
  assign sensor1      = sensor_q[0];
  assign sensor2      = sensor_q[1];
  assign sensor3      = sensor_q[2];
  assign sensor4      = sensor_q[3];
  assign timeout_mask = tmask_q;
  assign frame_valid  = fvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_sensors_acquire.sv
`default_nettype none
// ============================================================================
// Module   : tb_sensors_acquire
// Purpose  : Directed self-checking bench for sensors_acquire (TIMEOUT = 15).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sensors_acquire;

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy;
  logic [1:0] sns_sel;
  logic       sns_req;
  logic       sns_ack;
  logic [7:0] sns_data;
  logic [7:0] sensor1, sensor2, sensor3, sensor4;
  logic [3:0] timeout_mask;
  logic       frame_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Responder configuration: ack on WAIT cycle ack_at[s] (0 = never answer).
  int         ack_at   [4];
  logic [7:0] ack_data [4];
  int         req_sel  [4];
  int         nreq;
  int         fv_cycle;

  sensors_acquire #(.TIMEOUT(15), .TW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .sns_sel      (sns_sel),
    .sns_req      (sns_req),
    .sns_ack      (sns_ack),
    .sns_data     (sns_data),
    .sensor1      (sensor1),
    .sensor2      (sensor2),
    .sensor3      (sensor3),
    .sensor4      (sensor4),
    .timeout_mask (timeout_mask),
    .frame_valid  (frame_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                         input logic [7:0] e3, input logic [7:0] e4, input logic [3:0] em);
    chk({tag, "_s1"}, {24'd0, sensor1}, {24'd0, e1});
    chk({tag, "_s2"}, {24'd0, sensor2}, {24'd0, e2});
    chk({tag, "_s3"}, {24'd0, sensor3}, {24'd0, e3});
    chk({tag, "_s4"}, {24'd0, sensor4}, {24'd0, e4});
    chk({tag, "_mask"}, {28'd0, timeout_mask}, {28'd0, em});
  endtask

  // Called in cycle 1 (one cycle after the edge that sampled start). Runs the
  // responder until frame_valid is seen; fv_cycle stays -1 on a hung frame.
  task automatic run_frame(input bit ack_in_req, input int pulse_at);
    int wcnt;
    int cur;
    fv_cycle = -1;
    nreq     = 0;
    wcnt     = 0;
    cur      = 0;
    for (int c = 1; c <= 200; c++) begin
      if (frame_valid) begin
        fv_cycle = c;
        break;
      end
      sns_ack  = 1'b0;
      sns_data = 8'h00;
      if (pulse_at != 0) start = (c == pulse_at);
      if (sns_req) begin
        if (nreq < 4) req_sel[nreq] = int'(sns_sel);
        nreq++;
        cur  = int'(sns_sel);
        wcnt = 0;
        if (ack_in_req) begin
          sns_ack  = 1'b1;
          sns_data = 8'hEE;
        end
      end else if (busy) begin
        wcnt++;
        if (ack_at[cur] == wcnt) begin
          sns_ack  = 1'b1;
          sns_data = ack_data[cur];
        end
      end
      tick();
    end
    sns_ack  = 1'b0;
    sns_data = 8'h00;
    if (pulse_at != 0) start = 1'b0;
  endtask

  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_resp(input int a0, input int a1, input int a2, input int a3,
                          input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    ack_at[0] = a0; ack_at[1] = a1; ack_at[2] = a2; ack_at[3] = a3;
    ack_data[0] = d0; ack_data[1] = d1; ack_data[2] = d2; ack_data[3] = d3;
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; sns_ack = 1'b1; sns_data = 8'hAA;

    // 1. Reset dominates start and ack
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_req", {31'd0, sns_req}, 32'd0);
      chk("rst_sel", {30'd0, sns_sel}, 32'd0);
      chk("rst_fv", {31'd0, frame_valid}, 32'd0);
    end
    chk_out("rst", 8'd0, 8'd0, 8'd0, 8'd0, 4'b0000);
    start = 1'b0;
    rst   = 1'b0;
    tick();
    // ack in IDLE is ignored
    tick();
    sns_ack = 1'b0;
    tick();
    chk("idle_ack_busy", {31'd0, busy}, 32'd0);
    chk("idle_ack_fv", {31'd0, frame_valid}, 32'd0);

    // 2. Full frame, immediate acks
    set_resp(1, 1, 1, 1, 8'd10, 8'd20, 8'd30, 8'd40);
    launch();
    run_frame(1'b0, 0);
    chk("full_fv_cycle", fv_cycle, 32'd9);
    chk("full_nreq", nreq, 32'd4);
    chk("full_sel0", req_sel[0], 32'd0);
    chk("full_sel1", req_sel[1], 32'd1);
    chk("full_sel2", req_sel[2], 32'd2);
    chk("full_sel3", req_sel[3], 32'd3);
    chk("full_busy", {31'd0, busy}, 32'd0);
    chk_out("full", 8'd10, 8'd20, 8'd30, 8'd40, 4'b0000);
    tick();
    chk("full_fv_pulse", {31'd0, frame_valid}, 32'd0);
    chk_out("full_hold", 8'd10, 8'd20, 8'd30, 8'd40, 4'b0000);

    // 3. Sensor 3 never answers
    set_resp(1, 1, 0, 1, 8'd5, 8'd6, 8'd99, 8'd8);
    launch();
    run_frame(1'b0, 0);
    chk("to_fv_cycle", fv_cycle, 32'd23);
    chk_out("to", 8'd5, 8'd6, 8'd0, 8'd8, 4'b0100);

    // 4. Ack on the last WAIT cycle, acks during REQ, acked zero
    set_resp(1, 15, 1, 1, 8'd0, 8'h55, 8'd7, 8'd9);
    launch();
    run_frame(1'b1, 0);
    chk("bnd_fv_cycle", fv_cycle, 32'd23);
    chk("bnd_nreq", nreq, 32'd4);
    chk_out("bnd", 8'd0, 8'h55, 8'd7, 8'd9, 4'b0000);

    // 5a. start pulse mid-frame has no effect
    set_resp(1, 1, 1, 1, 8'd10, 8'd20, 8'd30, 8'd40);
    launch();
    run_frame(1'b0, 4);
    chk("mid_fv_cycle", fv_cycle, 32'd9);
    chk("mid_nreq", nreq, 32'd4);
    chk_out("mid", 8'd10, 8'd20, 8'd30, 8'd40, 4'b0000);
    tick();
    chk("mid_no_restart", {31'd0, busy}, 32'd0);

    // 5b. start held high: back-to-back frames
    start = 1'b1;
    tick();
    run_frame(1'b0, 0);
    chk("held_fv_cycle", fv_cycle, 32'd9);
    tick();
    chk("held_req", {31'd0, sns_req}, 32'd1);
    chk("held_sel", {30'd0, sns_sel}, 32'd0);
    start = 1'b0;
    chk_out("held_keep", 8'd10, 8'd20, 8'd30, 8'd40, 4'b0000);
    set_resp(1, 1, 1, 1, 8'd1, 8'd2, 8'd3, 8'd4);
    run_frame(1'b0, 0);
    chk("held2_fv_cycle", fv_cycle, 32'd9);
    chk_out("held2", 8'd1, 8'd2, 8'd3, 8'd4, 4'b0000);

    // 6. Reset mid-frame (after a 10,20,30,40 frame)
    set_resp(1, 1, 1, 1, 8'd10, 8'd20, 8'd30, 8'd40);
    launch();
    run_frame(1'b0, 0);
    chk_out("pre_rst", 8'd10, 8'd20, 8'd30, 8'd40, 4'b0000);
    tick();
    set_resp(1, 1, 0, 1, 8'd10, 8'd20, 8'd30, 8'd40);
    launch();
    begin
      int found;
      found = 0;
      for (int c = 0; c < 40 && found == 0; c++) begin
        if (busy && !sns_req && sns_sel == 2'd2) found = 1;
        else begin
          sns_ack  = busy && !sns_req;
          sns_data = 8'd77;
          tick();
          sns_ack  = 1'b0;
        end
      end
      chk("mid_rst_reach_sel2", found, 32'd1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_req", {31'd0, sns_req}, 32'd0);
    chk("mrst_fv", {31'd0, frame_valid}, 32'd0);
    chk_out("mrst", 8'd0, 8'd0, 8'd0, 8'd0, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mrst_quiet_fv", {31'd0, frame_valid}, 32'd0);
    end
    set_resp(1, 1, 1, 1, 8'd11, 8'd22, 8'd33, 8'd44);
    launch();
    run_frame(1'b0, 0);
    chk("clean_fv_cycle", fv_cycle, 32'd9);
    chk_out("clean", 8'd11, 8'd22, 8'd33, 8'd44, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
